// File: rtl/periph_bus_pkg.sv
// rtl/periph_bus_pkg.sv - shared types and default address map for the peripheral bus decoder
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic FAULT_UNMAPPED = 1'b0;
  localparam logic FAULT_TIMEOUT  = 1'b1;

  localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
  localparam logic [31:0] DMEM_MASK  = 32'hF000_0000;
  localparam logic [31:0] TBMAN_BASE = 32'h8000_F000;
  localparam logic [31:0] TBMAN_MASK = 32'hFFFF_F000;

endpackage

// File: rtl/periph_bus_decoder_addr_region_match.sv
// rtl/periph_bus_decoder_addr_region_match.sv - combinational base/mask window matcher
// Lowest-indexed matching window wins on overlap.
module addr_region_match
  import periph_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {TBMAN_BASE, DMEM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {TBMAN_MASK, DMEM_MASK},
  localparam int                      IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        idx = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/periph_bus_decoder.sv
// rtl/periph_bus_decoder.sv - address decoder and single-outstanding transaction sequencer
// Drives a registered chip select per slave, enforces an ack timeout and logs first fault.
module periph_bus_decoder
  import periph_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {TBMAN_BASE, DMEM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {TBMAN_MASK, DMEM_MASK},
  parameter int                       TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_be,
  output logic                     m_ready,
  output logic                     m_err,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_cs_n,
  output logic                     s_we,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_be,
  input  logic [NUM_SLAVES-1:0]    s_ack,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     fault_valid,
  output logic                     fault_cause,
  output logic [31:0]              fault_addr,
  input  logic                     fault_clr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] sel;
  logic [TW-1:0]    timer;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             sel_ack;
  logic [31:0]      sel_rdata;
  logic             accept, go_resp, resp_err;
  logic             fault_ev, fault_ev_cause;
  logic [31:0]      fault_ev_addr;

  addr_region_match #(
    .NUM_SLAVES(NUM_SLAVES),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_match (
    .addr(m_addr),
    .hit (hit),
    .idx (hit_idx)
  );

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == i[IDX_W-1:0]) begin
        sel_ack   = s_ack[i];
        sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    go_resp        = 1'b0;
    resp_err       = 1'b0;
    fault_ev       = 1'b0;
    fault_ev_cause = FAULT_UNMAPPED;
    fault_ev_addr  = m_addr;
    case (state)
      IDLE: begin
        if (m_req) begin
          if (hit) begin
            accept     = 1'b1;
            state_next = ACCESS;
          end else begin
            state_next = RESP;
            go_resp    = 1'b1;
            resp_err   = 1'b1;
            fault_ev   = 1'b1;
          end
        end
      end
      ACCESS: begin
        // An ack on the final timer count still counts as success.
        if (sel_ack) begin
          state_next = RESP;
          go_resp    = 1'b1;
        end else if (timer == TMAX) begin
          state_next     = RESP;
          go_resp        = 1'b1;
          resp_err       = 1'b1;
          fault_ev       = 1'b1;
          fault_ev_cause = FAULT_TIMEOUT;
          fault_ev_addr  = s_addr;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      timer       <= '0;
      s_cs_n      <= '1;
      s_we        <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_be        <= '0;
      m_ready     <= 1'b0;
      m_err       <= 1'b0;
      m_rdata     <= '0;
      fault_valid <= 1'b0;
      fault_cause <= FAULT_UNMAPPED;
      fault_addr  <= '0;
    end else begin
      state   <= state_next;
      m_ready <= go_resp;
      m_err   <= go_resp & resp_err;
      if (accept) begin
        s_we    <= m_we;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_be    <= m_be;
        sel     <= hit_idx;
        timer   <= '0;
        s_cs_n  <= ~(NUM_SLAVES'(1) << hit_idx);
      end else if (state == ACCESS) begin
        if (state_next != ACCESS) s_cs_n <= '1;
        else                      timer  <= timer + 1'b1;
      end
      if (go_resp) begin
        if (resp_err)   m_rdata <= '0;
        else if (!s_we) m_rdata <= sel_rdata;
      end
      // A clear coinciding with a new fault lets the new fault in.
      if (fault_ev && (!fault_valid || fault_clr)) begin
        fault_valid <= 1'b1;
        fault_cause <= fault_ev_cause;
        fault_addr  <= fault_ev_addr;
      end else if (fault_clr) begin
        fault_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/periph_bus_decoder.md
# periph_bus_decoder

Parametrised address decoder and transaction sequencer between the CPU data port and up to NUM_SLAVES memory-mapped peripherals (data memory, testbench manager, future devices). Each request is matched against per-slave base/mask windows. The decoder drives a registered active-low chip select, waits for the slave's acknowledge under a timeout, and returns read data plus an error flag to the master. Unmapped and timed-out accesses are logged in a sticky fault register.

## Interface
Parameters:
- NUM_SLAVES, 2: number of slave windows, 1..8.
- SLAVE_BASE, {32'h8000_F000, 32'h1000_0000}: packed NUM_SLAVES×32. Slice i is the base of slave i (slave 0 = dmem, slave 1 = tbman).
- SLAVE_MASK, {32'hFFFF_F000, 32'hF000_0000}: packed NUM_SLAVES×32 compare masks.
- TIMEOUT, 16: ACCESS cycles without ack before an error, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- m_req  in  1  master request, sampled only in IDLE.
- m_we  in  1  1 = write.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_be  in  4  byte enables.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error qualifier, valid only with m_ready.
- m_rdata  out  32  read data, registered.
- s_cs_n  out  NUM_SLAVES  active-low chip selects, at most one low.
- s_we, s_addr, s_wdata, s_be  out  1/32/32/4  registered copies of the accepted request.
- s_ack  in  NUM_SLAVES  per-slave completion.
- s_rdata  in  NUM_SLAVES×32  per-slave read data.
- fault_valid  out  1  sticky fault flag.
- fault_cause  out  1  0 = unmapped, 1 = timeout.
- fault_addr  out  32  address of the first fault.
- fault_clr  in  1  clears fault_valid.

## Operation
- Match: slave i hits when (m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]. On overlap the lowest index wins.
- IDLE, m_req=1:
  - On a hit at index k: latch s_we, s_addr, s_wdata, s_be and k; clear the timer; go to ACCESS.
  - On a miss: go to RESP with err=1 and record a fault (cause 0, m_addr).
- ACCESS: s_cs_n[k]=0, all other bits 1.
  - s_ack[k]=1: capture s_rdata[k] into m_rdata if it is a read (m_rdata unchanged for writes), set err=0, go to RESP.
  - Otherwise the timer increments. When the timer reaches TIMEOUT−1 with no ack, set err=1, record a fault (cause 1, s_addr), go to RESP.
- RESP: m_ready=1 and m_err=err for one cycle; s_cs_n all ones; go to IDLE. On err, m_rdata is set to 0.
- Acks from non-selected slaves, and any ack outside ACCESS, are ignored.
- m_req outside IDLE is ignored. A high m_req in the IDLE cycle after RESP is a new transaction.
- Fault register:
  - First fault wins; later faults are dropped while fault_valid=1.
  - fault_clr clears fault_valid only; fault_addr and fault_cause retain their last values.
  - fault_clr in the same cycle as a new fault: the new fault is recorded and fault_valid stays 1.

## Timing
- Reset values: state=IDLE, s_cs_n all ones, m_ready=0, m_err=0, m_rdata=0, s_* = 0, fault_valid=0, fault_cause=0, fault_addr=0, timer=0.
- Reset mid-ACCESS: on the next edge s_cs_n goes all ones and no m_ready is produced.
- Latency from the IDLE acceptance edge to the m_ready cycle:
  - Hit with ack in the first ACCESS cycle: 2 cycles.
  - Each extra wait cycle adds 1.
  - Unmapped: 1 cycle.
  - Timeout: TIMEOUT+1 cycles.
- An ack arriving in the same cycle the timer reaches TIMEOUT−1 is a success; the ack wins.
- All outputs are registered; no combinational path from m_* to s_cs_n.
- Timer width: $clog2(TIMEOUT+1) bits; it never wraps.

## Structure
- Package periph_bus_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - FAULT_UNMAPPED=1'b0 and FAULT_TIMEOUT=1'b1;
  - the default map constants (DMEM_BASE/MASK, TBMAN_BASE/MASK).
- Sub-module addr_region_match: combinational priority matcher taking addr and producing hit plus a $clog2(NUM_SLAVES)-bit index. It is parametrised identically and instantiated once.

## Test plan
- Read 0x1000_0040, slave 0 acks in the first ACCESS cycle with 0xDEAD_BEEF:
  - s_cs_n=2'b10 for 1 cycle;
  - m_ready 2 cycles after acceptance, m_err=0, m_rdata=0xDEAD_BEEF.
- Write 0x8000_F004, data 0x0000_0001, be 4'hF, slave 1 acks after 3 wait cycles:
  - s_cs_n=2'b01 for 4 cycles, s_wdata=1;
  - m_ready at cycle 5, m_err=0, m_rdata unchanged.
- Read 0x2000_0000 (unmapped):
  - no chip select; m_ready at cycle 1 with m_err=1, m_rdata=0;
  - fault_valid=1, fault_cause=0, fault_addr=0x2000_0000.
- Read 0x1000_0000 with no ack, TIMEOUT=16:
  - cs low for 16 cycles, m_ready/m_err at cycle 17;
  - fault_cause=1 recorded only if fault_valid was clear (second fault dropped); fault_clr+fault in the same cycle leaves fault_valid=1.
- Reset asserted during ACCESS (cycle 2 of a waiting read):
  - next edge s_cs_n=2'b11, no m_ready, all outputs at reset values;
  - a stray s_ack[1] in IDLE produces no response.
